// File: rtl/eth_10g_mac_rx_st_demux_flow_control_user_frame_pkg.sv
// Shared definitions for the 64-bit MAC user-frame ST mux/demux pair.
// Payload packing is {data, empty, eop, error, sop}, LSB = sop.
package eth_10g_mac_rx_st_demux_flow_control_user_frame_pkg;

   localparam int DATA_W    = 64;
   localparam int EMPTY_W   = 3;
   localparam int ERR_W     = 2;
   localparam int PAYLOAD_W = DATA_W + EMPTY_W + 1 + ERR_W + 1;  // 71

   localparam int SOP_OFS   = 0;
   localparam int ERR_OFS   = SOP_OFS + 1;
   localparam int EOP_OFS   = ERR_OFS + ERR_W;
   localparam int EMPTY_OFS = EOP_OFS + 1;
   localparam int DATA_OFS  = EMPTY_OFS + EMPTY_W;

   typedef enum logic {CH0 = 1'b0, CH1 = 1'b1} ch_t;
   typedef enum logic {IDLE = 1'b0, PKT = 1'b1} demux_st_t;

   // Pack the stream sideband and data into one payload word
   function automatic logic [PAYLOAD_W-1:0] pack_payload(
      input logic [DATA_W-1:0]  data,
      input logic [EMPTY_W-1:0] empty,
      input logic               eop,
      input logic [ERR_W-1:0]   error,
      input logic               sop);
      return {data, empty, eop, error, sop};
   endfunction

endpackage

// File: rtl/eth_10g_mac_rx_st_demux_flow_control_user_frame_1stage_pipeline.sv
// One-deep registered ST stage: holds payload while the consumer stalls,
// and accepts a new beat whenever empty or being popped this cycle.
module eth_10g_mac_rx_st_demux_1stage_pipeline #(
   parameter int PAYLOAD_WIDTH = 71
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     load,
   input  logic [PAYLOAD_WIDTH-1:0] payload_in,
   input  logic                     ready,
   output logic                     valid,
   output logic [PAYLOAD_WIDTH-1:0] payload,
   output logic                     stage_ready
);

   assign stage_ready = ready || !valid;

   // Load wins over pop so a simultaneous accept/pop keeps valid high
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         valid   <= 1'b0;
         payload <= '0;
      end else if (load) begin
         valid   <= 1'b1;
         payload <= payload_in;
      end else if (ready) begin
         valid   <= 1'b0;
      end
   end

endmodule

// File: rtl/eth_10g_mac_rx_st_demux_flow_control_user_frame.sv
// 1-to-2 packet-aware ST demux for the RX user-frame path.
// Optional statistics: define ETH_10G_MAC_RX_ST_DEMUX_STATS_EN to build the
// saturating counters; otherwise stat_* are tied to zero.
module eth_10g_mac_rx_st_demux_flow_control_user_frame
   import eth_10g_mac_rx_st_demux_flow_control_user_frame_pkg::*;
#(
   parameter int CNT_WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 in_channel,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [63:0]          in_data,
   input  logic [1:0]           in_error,
   input  logic                 in_startofpacket,
   input  logic                 in_endofpacket,
   input  logic [2:0]           in_empty,
   output logic                 out0_valid,
   input  logic                 out0_ready,
   output logic [63:0]          out0_data,
   output logic [1:0]           out0_error,
   output logic                 out0_startofpacket,
   output logic                 out0_endofpacket,
   output logic [2:0]           out0_empty,
   output logic                 out1_valid,
   input  logic                 out1_ready,
   output logic [63:0]          out1_data,
   output logic [1:0]           out1_error,
   output logic                 out1_startofpacket,
   output logic                 out1_endofpacket,
   output logic [2:0]           out1_empty,
   output logic [CNT_WIDTH-1:0] stat_pkt0,
   output logic [CNT_WIDTH-1:0] stat_pkt1,
   output logic [CNT_WIDTH-1:0] stat_drop,
   output logic [CNT_WIDTH-1:0] stat_sop_err
);

   demux_st_t              state;
   ch_t                    locked;
   ch_t                    tgt;
   logic                   is_drop;
   logic                   accept;
   logic                   fwd;
   logic                   rdy0, rdy1;
   logic [PAYLOAD_W-1:0]   in_payload, p0, p1;

   // Any SOP beat starts a frame on in_channel (including a relock mid-packet);
   // body beats follow the locked channel
   always_comb begin
      tgt = locked;
      if (state == IDLE || in_startofpacket) tgt = ch_t'(in_channel);
   end

   // Non-SOP beats in IDLE are orphans: always accepted and thrown away
   assign is_drop    = (state == IDLE) && !in_startofpacket;
   assign in_ready   = is_drop ? 1'b1 : ((tgt == CH1) ? rdy1 : rdy0);
   assign accept     = in_valid && in_ready;
   assign fwd        = accept && !is_drop;
   assign in_payload = pack_payload(in_data, in_empty, in_endofpacket, in_error, in_startofpacket);

   eth_10g_mac_rx_st_demux_1stage_pipeline #(.PAYLOAD_WIDTH(PAYLOAD_W)) u_stage0 (
      .clk         (clk),
      .reset_n     (reset_n),
      .load        (fwd && (tgt == CH0)),
      .payload_in  (in_payload),
      .ready       (out0_ready),
      .valid       (out0_valid),
      .payload     (p0),
      .stage_ready (rdy0)
   );

   eth_10g_mac_rx_st_demux_1stage_pipeline #(.PAYLOAD_WIDTH(PAYLOAD_W)) u_stage1 (
      .clk         (clk),
      .reset_n     (reset_n),
      .load        (fwd && (tgt == CH1)),
      .payload_in  (in_payload),
      .ready       (out1_ready),
      .valid       (out1_valid),
      .payload     (p1),
      .stage_ready (rdy1)
   );

   assign out0_data          = p0[DATA_OFS +: DATA_W];
   assign out0_empty         = p0[EMPTY_OFS +: EMPTY_W];
   assign out0_endofpacket   = p0[EOP_OFS];
   assign out0_error         = p0[ERR_OFS +: ERR_W];
   assign out0_startofpacket = p0[SOP_OFS];
   assign out1_data          = p1[DATA_OFS +: DATA_W];
   assign out1_empty         = p1[EMPTY_OFS +: EMPTY_W];
   assign out1_endofpacket   = p1[EOP_OFS];
   assign out1_error         = p1[ERR_OFS +: ERR_W];
   assign out1_startofpacket = p1[SOP_OFS];

   // Frame FSM: lock channel on SOP, release on an accepted EOP
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state  <= IDLE;
         locked <= CH0;
      end else if (fwd) begin
         if (in_startofpacket) locked <= ch_t'(in_channel);
         state <= in_endofpacket ? IDLE : PKT;
      end
   end

`ifdef ETH_10G_MAC_RX_ST_DEMUX_STATS_EN
   logic [CNT_WIDTH-1:0] c_pkt0, c_pkt1, c_drop, c_sop_err;

   // Saturating statistics, updated the cycle after the counted accept
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         c_pkt0    <= '0;
         c_pkt1    <= '0;
         c_drop    <= '0;
         c_sop_err <= '0;
      end else begin
         if (fwd && in_endofpacket && (tgt == CH0) && (c_pkt0 != '1)) c_pkt0 <= c_pkt0 + 1'b1;
         if (fwd && in_endofpacket && (tgt == CH1) && (c_pkt1 != '1)) c_pkt1 <= c_pkt1 + 1'b1;
         if (accept && is_drop && (c_drop != '1))                     c_drop <= c_drop + 1'b1;
         if (fwd && (state == PKT) && in_startofpacket && (c_sop_err != '1))
            c_sop_err <= c_sop_err + 1'b1;
      end
   end

   assign stat_pkt0    = c_pkt0;
   assign stat_pkt1    = c_pkt1;
   assign stat_drop    = c_drop;
   assign stat_sop_err = c_sop_err;
`else
   assign stat_pkt0    = '0;
   assign stat_pkt1    = '0;
   assign stat_drop    = '0;
   assign stat_sop_err = '0;
`endif

endmodule

// File: doc/eth_10g_mac_rx_st_demux_flow_control_user_frame.md
Name: eth_10g_mac_rx_st_demux_flow_control_user_frame

Overview:
- Packet-aware 1-to-2 Avalon-ST demultiplexer on the 64-bit MAC user-frame datapath, the receive-side counterpart of the 2-to-1 TX frame mux.
- Steers each frame from a single channel-tagged input stream to out0 or out1, locking the destination for the whole packet.
- Each output is driven through a one-stage registered pipeline with back-pressure.

Parameters:
- CNT_WIDTH, 16, width of the saturating statistics counters (used only with the optional feature).

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous, active-low reset.
- in_channel  in  1  destination output; sampled only on SOP beats.
- in_valid  in  1  input beat valid.
- in_ready  out  1  input beat accepted when in_valid && in_ready.
- in_data  in  64  frame data.
- in_error  in  2  error flags.
- in_startofpacket  in  1  SOP.
- in_endofpacket  in  1  EOP.
- in_empty  in  3  empty bytes on the EOP beat.
- out0_valid, out0_ready, out0_data[64], out0_error[2], out0_startofpacket, out0_endofpacket, out0_empty[3]  out/in/out...  channel-0 stream (ready is an input).
- out1_* : same set as out0_*, channel-1 stream.
- stat_pkt0, stat_pkt1  out  CNT_WIDTH  frames delivered per channel.
- stat_drop  out  CNT_WIDTH  beats discarded.
- stat_sop_err  out  CNT_WIDTH  SOP seen mid-packet.

Behaviour:
- Reset (async assert, sync-to-clk release): all out*_valid=0, all payload registers=0, FSM=IDLE, locked channel=0, all stat_*=0.
- Clock and reset: one clock (clk); reset_n is asynchronous and active-low.
- Payload order {data, empty, eop, error, sop}: 71 bits, identical to the TX side.
- FSM, two states:
  - IDLE: a beat with SOP sets locked=in_channel and routes to that output. With EOP also set (single-beat frame), stay in IDLE; otherwise go to PKT.
  - IDLE, beat without SOP: the beat is accepted (in_ready=1), discarded, and stat_drop++.
  - PKT: beats route to the locked channel; in_channel is ignored. An accepted EOP returns the FSM to IDLE.
  - PKT, SOP beat: treated as the start of a new frame. Relock to in_channel, stat_sop_err++. The previous frame is not terminated, and its downstream consumer sees no EOP.
- Route target: in IDLE it is in_channel; in PKT it is locked.
- in_ready equals stage_ready of the route target. During a drop in IDLE, in_ready is forced to 1.
- Per-stage ready: stage_ready = outN_ready || !outN_valid. A stalled channel never blocks the other channel's in-flight data, but the single input does stall.
- Per-stage update:
  - On accept to stage N: outN_valid<=1 and payload<=input.
  - Otherwise, if outN_ready: outN_valid<=0.
  - Simultaneous accept and downstream pop: the stage reloads and outN_valid stays 1.
- Latency is 1 cycle from input accept to outN_valid. Full throughput is one beat per cycle per channel when the target ready is held high.
- Payload stays stable while outN_valid && !outN_ready.
- Counters are saturating at 2^CNT_WIDTH-1 (no wrap).
  - stat_pktN increments on an accepted EOP routed to N.
  - Counter increments take effect the cycle after the accept.
- Reset mid-packet: the frame is abandoned, both stages empty, and the FSM returns to IDLE. No partial-frame flush is performed.

Optional Feature:
- Macro: ETH_10G_MAC_RX_ST_DEMUX_STATS_EN.
- Defined: the four saturating counters are implemented as described.
- Undefined: the counters are not synthesized and stat_* are tied to 0. Routing, drop and relock behaviour are unchanged.

Decomposition:
- Shared package: payload width constant (71), field offset/width constants for data/empty/eop/error/sop, and a channel typedef (CH0/CH1). The same package serves the TX mux.
- One sub-module, eth_10g_mac_rx_st_demux_1stage_pipeline (parameter PAYLOAD_WIDTH), instantiated twice. It provides valid/ready/payload registers and stage_ready.
- FSM, routing and counters stay in the top level.

Test Plan:
- Channel lock: 3-beat frame with SOP channel=1, then in_channel toggled to 0 on beats 2-3, all readies=1 → all 3 beats appear on out1 one cycle after each accept; out0_valid stays 0; stat_pkt1=1.
- Single-beat frames: alternating ch0/ch1 frames with SOP=EOP=1 on every cycle → out0 and out1 each carry every other beat; throughput is 1/cycle; stat_pkt0 = stat_pkt1 = N/2.
- Back-pressure isolation: out1_ready=0 while out1_valid=1, frame targeting ch1 → in_ready=0, out1 payload held. Raise out1_ready → transfer resumes with no loss or duplication. A subsequent ch0 frame is unaffected.
- Orphan beat: beat without SOP in IDLE (data=64'hDEAD) → in_ready=1, no outN_valid, stat_drop=1.
- SOP mid-packet: ch0 SOP, one body beat, then SOP ch1 → second frame routed to out1, stat_sop_err=1. Assert reset_n=0 mid-frame → both valids 0 asynchronously, FSM=IDLE, counters=0.
